// File: rtl/multicycle_control_unit.sv
// Main control FSM for a multicycle MIPS datapath.
// Moore machine: one state register, outputs decoded from the current state.
// There are two exceptions. In FETCH, ir_write and pc_write follow mem_ready.
// In I_EXEC, alu_op follows the opcode.
// Memory states hold until mem_ready; unsupported opcodes park the FSM in HALT.
// Optional feature: define MULTICYCLE_BEQ_EN to add the BEQ state (11) and
// drive pc_write_cond; without it opcode 000100 is illegal.
module multicycle_control_unit #(
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic                   illegal_op,
    output logic [STATE_WIDTH-1:0] state_out
);

    typedef enum logic [STATE_WIDTH-1:0] {
        FETCH     = STATE_WIDTH'(0),
        DECODE    = STATE_WIDTH'(1),
        MEM_ADDR  = STATE_WIDTH'(2),
        MEM_READ  = STATE_WIDTH'(3),
        MEM_WB    = STATE_WIDTH'(4),
        MEM_WRITE = STATE_WIDTH'(5),
        R_EXEC    = STATE_WIDTH'(6),
        R_WB      = STATE_WIDTH'(7),
        I_EXEC    = STATE_WIDTH'(8),
        I_WB      = STATE_WIDTH'(9),
        JUMP      = STATE_WIDTH'(10),
        BEQ_EXEC  = STATE_WIDTH'(11),
        HALT      = STATE_WIDTH'(15)
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_BEQ_EN
    localparam logic [5:0] OP_BEQ  = 6'b000100;
`endif

    // ALU control decoder codes
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_R   = 3'b111;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_OR  = 3'b101;
`ifdef MULTICYCLE_BEQ_EN
    localparam logic [2:0] ALU_SUB = 3'b011;
`endif

    state_t state_reg;
    state_t state_next;

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: memory states wait on mem_ready, HALT is absorbing
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:     state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_R:                      state_next = R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_next = I_EXEC;
                    OP_LW, OP_SW:              state_next = MEM_ADDR;
                    OP_J:                      state_next = JUMP;
`ifdef MULTICYCLE_BEQ_EN
                    OP_BEQ:                    state_next = BEQ_EXEC;
`endif
                    default:                   state_next = HALT;
                endcase
            end
            MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_next = MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_next = MEM_WRITE;
                end else begin
                    state_next = HALT;
                end
            end
            MEM_READ:  state_next = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    state_next = FETCH;
            MEM_WRITE: state_next = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    state_next = R_WB;
            R_WB:      state_next = FETCH;
            I_EXEC:    state_next = I_WB;
            I_WB:      state_next = FETCH;
            JUMP:      state_next = FETCH;
`ifdef MULTICYCLE_BEQ_EN
            BEQ_EXEC:  state_next = FETCH;
`endif
            HALT:      state_next = HALT;
            default:   state_next = HALT;
        endcase
    end

    // Output decode from state; every strobe is forced low while reset is high
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_R;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            I_WB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MULTICYCLE_BEQ_EN
            BEQ_EXEC: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
`endif
            HALT: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 3'b000;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
        end
    end

    assign state_out = state_reg;

endmodule
